// File: rtl/spi_inert_serf.sv
// ---------------------------------------------------------------------------
// spi_inert_serf
//   Clocked inertial-sensor SPI serf. Parallel samples are queued in a small
//   FIFO and served over a mode-3 SPI serf port. The serf also provides a
//   128x8 register file, a status register and a data-ready interrupt.
//
//   Optional feature macro: SPI_BURST_EN
//     defined   : address auto-increments after every completed data byte
//                 (7'h7F wraps to 7'h00), so multi-byte bursts are possible
//     undefined : address is fixed for the whole transaction
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   SS_n       serf select, active low
//   SCLK       SPI clock, idle high
//   MOSI       serial data from monarch
//   MISO       serial data to monarch, Z while SS_n is high
//   INT        data-ready interrupt (FIFO non-empty and sampling enabled)
//   smpl_vld   one-cycle strobe qualifying smpl_data
//   smpl_data  NUM_CH x 16-bit sample, channel k at [16k+15:16k]
//   fifo_cnt   current FIFO occupancy
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_inert_serf #(
  parameter int         NUM_CH     = 6,
  parameter int         DEPTH      = 4,
  parameter logic [7:0] WHO_AM_I   = 8'h6A,
  parameter logic [6:0] DATA_BASE  = 7'h22,
  parameter logic [6:0] STAT_ADDR  = 7'h1E,
  parameter logic [6:0] CFG_ADDR   = 7'h0D,
  parameter logic [7:0] CFG_EN_VAL = 8'h02
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SS_n,
  input  logic                         SCLK,
  input  logic                         MOSI,
  output logic                         MISO,
  output logic                         INT,
  input  logic                         smpl_vld,
  input  logic [NUM_CH*16-1:0]         smpl_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

  localparam int         CW        = $clog2(DEPTH+1);
  localparam int         PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         SW        = $clog2(NUM_CH*16);
  localparam int         DW        = NUM_CH*16;
  localparam logic [7:0] DATA_SPAN = 8'(2*NUM_CH);
  localparam logic [7:0] WR_RESP   = 8'hA5;
  localparam logic [6:0] WHO_ADDR  = 7'h0F;

  // True when the address falls inside the sample data window.
  function automatic logic f_is_data(input logic [6:0] a);
    logic [7:0] off;
    off = {1'b0, a} - {1'b0, DATA_BASE};
    return (a >= DATA_BASE) && (off < DATA_SPAN);
  endfunction

  // Read-only locations that a write must never touch.
  function automatic logic f_wr_protected(input logic [6:0] a);
    return (a == WHO_ADDR) || (a == STAT_ADDR) || f_is_data(a);
  endfunction

  // Synchronisers and edge-detect history
  logic [1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic       r_ss_d, r_sclk_d;

  // SPI framing state
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic       r_in_data;
  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_tx;
  logic [7:0] r_resp;
  logic       r_load_pend;
  logic       r_resp_data;
  logic       r_resp_stat;
  logic       r_data_rd;
  logic       r_stat_rd;

  // Storage
  logic [7:0]    r_regs [128];
  logic [DW-1:0] r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovr;
  logic          r_int;

  // Derived signals
  logic          w_ss, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;
  logic [7:0]    w_byte;
  logic          w_rw_eff;
  logic [6:0]    w_next_addr, w_rd_addr, w_rd_off;
  logic          w_rd_is_data, w_rd_is_stat;
  logic [DW-1:0] w_head;
  logic [SW-1:0] w_bit_sel;
  logic [7:0]    w_head_byte, w_rd_byte;
  logic          w_byte_done, w_wr_en;
  logic          w_enabled, w_not_empty, w_full, w_push, w_pop, w_overrun;

  assign w_ss        = r_ss_sync[1];
  assign w_ss_fall   = r_ss_d & ~w_ss;
  assign w_ss_rise   = ~r_ss_d & w_ss;
  assign w_sclk_rise = ~w_ss & ~r_sclk_d & r_sclk_sync[1];
  assign w_sclk_fall = ~w_ss & r_sclk_d & ~r_sclk_sync[1];
  assign w_mosi      = r_mosi_sync[1];

  assign w_byte      = {r_rx, w_mosi};
  assign w_byte_done = w_sclk_rise & ~w_ss_fall & (r_bit_cnt == 3'd7);
  // Byte 0 carries R/Wn itself; later bytes use the latched direction.
  assign w_rw_eff    = r_in_data ? r_rw : w_byte[7];
`ifdef SPI_BURST_EN
  assign w_next_addr = r_addr + 7'd1;
`else
  assign w_next_addr = r_addr;
`endif
  // Response is always for the address of the *next* byte to be shifted.
  assign w_rd_addr    = r_in_data ? w_next_addr : w_byte[6:0];
  assign w_rd_off     = w_rd_addr - DATA_BASE;
  assign w_rd_is_data = f_is_data(w_rd_addr);
  assign w_rd_is_stat = (w_rd_addr == STAT_ADDR);
  assign w_head       = r_fifo[r_rd_ptr];
  // Data window byte offset n maps straight to head bits [8n+7:8n].
  assign w_bit_sel    = SW'({w_rd_off, 3'b000});
  assign w_head_byte  = w_head[w_bit_sel +: 8];

  assign w_wr_en     = w_byte_done & r_in_data & ~r_rw & ~f_wr_protected(r_addr);

  assign w_enabled   = (r_regs[CFG_ADDR] == CFG_EN_VAL);
  assign w_not_empty = (r_cnt != {CW{1'b0}});
  assign w_full      = (r_cnt == CW'(DEPTH));
  assign w_push      = smpl_vld & w_enabled;
  assign w_pop       = w_ss_rise & r_data_rd & w_not_empty;
  assign w_overrun   = w_push & w_full & ~w_pop;

  assign MISO     = SS_n ? 1'bz : r_tx[7];
  assign INT      = r_int;
  assign fifo_cnt = r_cnt;

  // Read multiplexer for the response byte.
  always_comb begin
    w_rd_byte = r_regs[w_rd_addr];
    if (w_rd_addr == WHO_ADDR) begin
      w_rd_byte = WHO_AM_I;
    end else if (w_rd_is_data) begin
      if (w_not_empty) w_rd_byte = w_head_byte;
      else             w_rd_byte = 8'h00;
    end else if (w_rd_is_stat) begin
      w_rd_byte = {6'b000000, r_ovr, w_not_empty};
    end else begin
      w_rd_byte = r_regs[w_rd_addr];
    end
  end

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_sync   <= 2'b11;
      r_sclk_sync <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
    end else begin
      r_ss_sync   <= {r_ss_sync[0], SS_n};
      r_sclk_sync <= {r_sclk_sync[0], SCLK};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_ss_d      <= r_ss_sync[1];
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  // SPI framing: receive shifting, response pipeline and tx shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'h00;
      r_in_data   <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= 7'h00;
      r_tx        <= 8'h00;
      r_resp      <= 8'h00;
      r_load_pend <= 1'b0;
      r_resp_data <= 1'b0;
      r_resp_stat <= 1'b0;
      r_data_rd   <= 1'b0;
      r_stat_rd   <= 1'b0;
    end else if (w_ss_fall) begin
      r_bit_cnt   <= 3'd0;
      r_in_data   <= 1'b0;
      r_tx        <= 8'h00;
      r_load_pend <= 1'b0;
      r_resp_data <= 1'b0;
      r_resp_stat <= 1'b0;
      r_data_rd   <= 1'b0;
      r_stat_rd   <= 1'b0;
    end else if (w_ss_rise) begin
      // Flags are consumed by the FIFO/overrun logic in this same cycle.
      r_load_pend <= 1'b0;
      r_data_rd   <= 1'b0;
      r_stat_rd   <= 1'b0;
    end else if (w_sclk_rise) begin
      r_rx      <= w_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) begin
        r_load_pend <= 1'b1;
        r_in_data   <= 1'b1;
        if (!r_in_data) begin
          r_rw   <= w_byte[7];
          r_addr <= w_byte[6:0];
        end else begin
          r_addr <= w_next_addr;
          // A read data byte just completed: its source counts as read.
          if (r_rw) begin
            r_data_rd <= r_data_rd | r_resp_data;
            r_stat_rd <= r_stat_rd | r_resp_stat;
          end
        end
        if (w_rw_eff) begin
          r_resp      <= w_rd_byte;
          r_resp_data <= w_rd_is_data;
          r_resp_stat <= w_rd_is_stat;
        end else begin
          r_resp      <= WR_RESP;
          r_resp_data <= 1'b0;
          r_resp_stat <= 1'b0;
        end
      end
    end else if (w_sclk_fall) begin
      if (r_load_pend) begin
        r_tx        <= r_resp;
        r_load_pend <= 1'b0;
      end else begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // Register file, written at the 8th rise of each accepted data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) r_regs[i] <= 8'h00;
    end else if (w_wr_en) begin
      r_regs[r_addr] <= w_byte;
    end
  end

  // Sample FIFO, overrun flag and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= {DW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_ovr    <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= smpl_data;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      // Overrun drops the oldest entry, so the read side advances too.
      if (w_pop | w_overrun) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   if (!w_full) r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_overrun)                  r_ovr <= 1'b1;
      else if (w_ss_rise & r_stat_rd) r_ovr <= 1'b0;
      r_int <= w_not_empty & w_enabled;
    end
  end

endmodule

// File: tb/tb_spi_inert_serf.sv
`timescale 1ns/1ps
module tb_spi_inert_serf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        smpl_vld = 1'b0;
  logic [95:0] smpl_data = 96'h0;
  wire         MISO;
  wire         INT;
  wire  [2:0]  fifo_cnt;

  spi_inert_serf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .smpl_vld(smpl_vld), .smpl_data(smpl_data),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_regs [128];
  logic [95:0] m_q [$];
  bit          m_ovr;

  function automatic bit m_enabled();
    return m_regs[13] == 8'h02;
  endfunction

  function automatic bit m_in_data(input logic [6:0] a);
    return (int'(a) >= 34) && (int'(a) < 34 + 12);
  endfunction

  function automatic logic [7:0] m_read(input logic [6:0] a);
    logic [95:0] h;
    int off;
    if (a == 7'h0F) return 8'h6A;
    if (m_in_data(a)) begin
      if (m_q.size() == 0) return 8'h00;
      h = m_q[0];
      off = int'(a) - 34;
      return h[off*8 +: 8];
    end
    if (a == 7'h1E) return {6'b000000, m_ovr, m_q.size() != 0};
    return m_regs[a];
  endfunction

  function automatic void m_write(input logic [6:0] a, input logic [7:0] d);
    if (!(a == 7'h0F || a == 7'h1E || m_in_data(a))) m_regs[a] = d;
  endfunction

  function automatic void m_push(input logic [95:0] d);
    if (m_enabled()) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovr = 1'b1;
      end
      m_q.push_back(d);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = 8'h00;
    m_q.delete();
    m_ovr = 1'b0;
  endfunction

  // ---------------- SPI monarch ----------------
  logic [7:0] tx_b [16];
  logic [7:0] rx_b [16];

  task automatic spi_txn(input int nbytes, input int extra_bits,
                         input bit push_end, input logic [95:0] pdata);
    int total;
    total = nbytes + ((extra_bits > 0) ? 1 : 0);
    SS_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int b = 0; b < total; b++) begin
      rx_b[b] = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        if (b == nbytes && (7 - k) >= extra_bits) break;
        SCLK = 1'b0;
        MOSI = tx_b[b][k];
        repeat (5) @(posedge clk);
        #1;
        rx_b[b][k] = MISO;
        SCLK = 1'b1;
        repeat (5) @(posedge clk);
        #1;
      end
    end
    SS_n = 1'b1;
    if (push_end) begin
      // Land the push on the cycle the synchronised SS_n rise is acted on.
      repeat (2) @(posedge clk);
      #1;
      smpl_vld = 1'b1;
      smpl_data = pdata;
      @(posedge clk);
      #1;
      smpl_vld = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    chk_val("fifo_cnt", fifo_cnt, m_q.size());
    chk_val("int", INT, (m_q.size() != 0) && m_enabled());
  endtask

  // One transaction plus its model update; tx_b[1..] must be set by the caller.
  task automatic do_txn(input logic rw, input logic [6:0] addr, input int ndata,
                        input int extra_bits, input bit push_end, input logic [95:0] pdata);
    logic [6:0] a;
    bit drd, srd;
    tx_b[0] = {rw, addr};
    spi_txn(1 + ndata, extra_bits, push_end, pdata);
    chk_val("byte0", rx_b[0], 8'h00);
    a = addr;
    drd = 1'b0;
    srd = 1'b0;
    for (int i = 1; i <= ndata; i++) begin
      if (rw) begin
        chk_val("rd_byte", rx_b[i], m_read(a));
        if (m_in_data(a)) drd = 1'b1;
        if (a == 7'h1E)   srd = 1'b1;
      end else begin
        chk_val("wr_resp", rx_b[i], 8'hA5);
        m_write(a, tx_b[i]);
      end
`ifdef SPI_BURST_EN
      a = a + 7'd1;
`endif
    end
    if (drd && m_q.size() != 0) void'(m_q.pop_front());
    if (srd) m_ovr = 1'b0;
    if (push_end) m_push(pdata);
    check_state();
  endtask

  task automatic wr1(input logic [6:0] a, input logic [7:0] d);
    tx_b[1] = d;
    do_txn(1'b0, a, 1, 0, 1'b0, 96'h0);
  endtask

  task automatic rd(input logic [6:0] a, input int n);
    for (int i = 1; i <= n; i++) tx_b[i] = 8'($urandom);
    do_txn(1'b1, a, n, 0, 1'b0, 96'h0);
  endtask

  task automatic push_smpl(input logic [95:0] d);
    @(negedge clk);
    smpl_vld = 1'b1;
    smpl_data = d;
    @(negedge clk);
    smpl_vld = 1'b0;
    m_push(d);
  endtask

  function automatic logic [95:0] rnd_smpl();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    int op;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_int", INT, 1'b0);
    chk_val("rst_cnt", fifo_cnt, 3'd0);
    chk_val("rst_miso_z", MISO === 1'bz, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // WHO_AM_I and tri-state after deselect
    rd(7'h0F, 1);
    chk_val("miso_z", MISO === 1'bz, 1'b1);

    // enable, push the known sample, watch INT one clock behind the push
    wr1(7'h0D, 8'h02);
    rd(7'h0D, 1);
    @(negedge clk);
    smpl_vld = 1'b1;
    smpl_data = {16'hABCD, 16'h1357, 16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    @(negedge clk);
    smpl_vld = 1'b0;
    m_push(smpl_data);
    chk_val("push_cnt", fifo_cnt, 3'd1);
    chk_val("int_lag", INT, 1'b0);
    @(negedge clk);
    chk_val("int_rise", INT, 1'b1);
    rd(7'h22, 12);

    // overrun: five pushes into four entries
    for (int i = 0; i < 5; i++) push_smpl(rnd_smpl());
    repeat (2) @(negedge clk);
    check_state();
    rd(7'h1E, 1);
    rd(7'h1E, 1);
    rd(7'h22, 12);
    rd(7'h22, 1);

    // push coincident with the popping SS_n rise at two entries
    chk_val("pre_coinc_cnt", fifo_cnt, 3'd2);
    tx_b[1] = 8'h00;
    do_txn(1'b1, 7'h22, 1, 0, 1'b1, rnd_smpl());
    rd(7'h1E, 1);

    // early end after four bits of the next byte
    tx_b[1] = 8'h5A;
    tx_b[2] = 8'hFF;
    do_txn(1'b0, 7'h10, 1, 4, 1'b0, 96'h0);
    rd(7'h10, 1);
    rd(7'h11, 1);
    wr1(7'h0F, 8'h33);
    rd(7'h0F, 1);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          push_smpl(rnd_smpl());
          repeat (2) @(negedge clk);
          check_state();
        end
        1: begin
          for (int i = 1; i <= 3; i++) tx_b[i] = 8'($urandom);
          do_txn(1'b0, 7'($urandom_range(0, 127)), $urandom_range(1, 3), 0, 1'b0, 96'h0);
        end
        2: begin
          case ($urandom_range(0, 4))
            0:       a = 7'h0F;
            1:       a = 7'h1E;
            2:       a = 7'h0D;
            3:       a = 7'(34 + $urandom_range(0, 11));
            default: a = 7'($urandom_range(0, 127));
          endcase
          rd(a, $urandom_range(1, 4));
        end
        3: rd(7'(34 + $urandom_range(0, 11)), $urandom_range(1, 4));
        default: wr1(7'h0D, 8'h02);
      endcase
    end

    // reset in the middle of a burst with three entries queued
    wr1(7'h0D, 8'h02);
    while (m_q.size() > 0) rd(7'h22, 1);
    for (int i = 0; i < 3; i++) push_smpl(rnd_smpl());
    repeat (2) @(negedge clk);
    chk_val("pre_rst_cnt", fifo_cnt, 3'd3);
    SS_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tx_b[0] = 8'hA2;
    for (int k = 0; k < 12; k++) begin
      SCLK = 1'b0;
      MOSI = tx_b[0][7 - (k % 8)];
      repeat (5) @(posedge clk);
      #1;
      SCLK = 1'b1;
      repeat (5) @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    chk_val("mid_rst_int", INT, 1'b0);
    chk_val("mid_rst_cnt", fifo_cnt, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(7'h0D, 1);
    push_smpl(rnd_smpl());
    repeat (2) @(negedge clk);
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_inert_serf.md
Name: spi_inert_serf

Overview:
- Synthesizable, clocked successor to the behavioural inertial-sensor SPI serf model.
- Takes inertial samples from a parallel port into a FIFO and serves them over a mode-3 SPI serf interface, with a 128x8 register file, a status register and a data-ready interrupt.
- Parametrised in channel count, FIFO depth and register map.
- Sits between the sensor stimulus/source and the SPI monarch in the flight-controller bench and FPGA build.

Parameters:
NUM_CH, 6, number of 16-bit inertial channels per sample
DEPTH, 4, sample FIFO entries (power of 2, >=2)
WHO_AM_I, 8'h6A, value returned at address 7'h0F
DATA_BASE, 7'h22, address of channel 0 low byte
STAT_ADDR, 7'h1E, status register address
CFG_ADDR, 7'h0D, enable register address
CFG_EN_VAL, 8'h02, value of CFG_ADDR that enables sampling

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
SS_n  in  1  serf select, active low
SCLK  in  1  SPI clock, idle high
MOSI  in  1  serial data from monarch
MISO  out  1  serial data to monarch, tri-stated when SS_n high
INT  out  1  data-ready interrupt, active high
smpl_vld  in  1  one-cycle strobe: smpl_data valid
smpl_data  in  NUM_CH*16  channel k at bits [16k+15:16k]
fifo_cnt  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- **Reset:** INT=0, fifo_cnt=0, registers all 8'h00, overrun=0, bit count 0.
- **MISO:** Z while SS_n high, otherwise tx shift register bit 7.
- **Synchronisers:** SS_n, SCLK and MOSI each pass through a 2-flop synchroniser; SS_n/SCLK flops preset to 1.
  - Edge detection is done on the synchronised versions.
  - SCLK high and low phases are each >= 4 clk; behaviour is undefined below that.
- **SPI framing:**
  - SS_n fall clears the bit counter, the byte index and the tx register.
  - MOSI is sampled on detected SCLK rise, MSB first.
  - Byte 0 = {R/Wn, addr[6:0]}; R/Wn=1 means read.
  - MISO drives 0 during byte 0.
- **Response pipeline:**
  - On the 8th rise of byte n, the response byte for the current address is computed and held.
  - The next detected SCLK fall loads it into the tx register; each subsequent fall shifts left.
- **Read map:**
  - 7'h0F returns WHO_AM_I.
  - DATA_BASE+2k returns head-entry channel k [7:0]; DATA_BASE+2k+1 returns channel k [15:8], for k < NUM_CH. An empty FIFO returns 8'h00.
  - STAT_ADDR returns {6'b0, overrun, fifo_cnt!=0}.
  - Any other address returns the register-file contents.
- **Writes:**
  - Response bytes are 8'hA5.
  - A data byte is committed to the register file at its 8th rise.
  - Writes to 7'h0F, STAT_ADDR and the data range are ignored.
- **Addressing:** the address auto-increments after each completed data byte and wraps 7'h7F->7'h00 (see Optional Feature).
- **Early end:** SS_n rise mid-byte discards the partial byte; bytes already completed stand.
- **Snapshot:** the head entry is not popped during a transaction, so a burst sees one coherent sample.
- **FIFO push and pop:**
  - Push on smpl_vld only when registers[CFG_ADDR]==CFG_EN_VAL; otherwise the sample is dropped silently.
  - Pop occurs on SS_n rise if any data-range byte was read in that transaction and fifo_cnt!=0.
  - Simultaneous push and pop both take effect; fifo_cnt is unchanged.
  - Push when full with no pop in the same cycle: the oldest entry is discarded, the new one is written, fifo_cnt stays DEPTH, overrun=1.
  - Push when full with a simultaneous pop: no overrun.
- **Overrun flag:** sticky; cleared on SS_n rise after a transaction that read STAT_ADDR. A simultaneous new overrun wins.
- **INT:** registered, equals (fifo_cnt!=0) && enabled. It rises 1 clk after a push and falls 1 clk after the pop that empties the FIFO.
- **Reset mid-transaction:** everything returns to reset values; the next transaction needs a fresh SS_n fall.

Optional Feature:
- Macro: SPI_BURST_EN.
- Defined: the address auto-increments after each completed data byte, wrapping 7'h7F->7'h00; multi-byte reads and writes are allowed.
- Undefined: the address stays fixed for the whole transaction; every data byte re-reads the same address or rewrites the same register.

Test Plan:
- Read 7'h0F (send 8'h8F then 8'h00) -> MISO byte 1 = 8'h6A; MISO Z after SS_n rise.
- Write 7'h0D=8'h02, push sample ch0=16'h1234..ch5=16'hABCD, burst-read 12 bytes from 8'hA2 (SPI_BURST_EN) -> bytes 34,12,...,CD,AB; INT high 1 clk after push and low after SS_n rise; fifo_cnt 1->0.
- Enabled, push 5 samples with DEPTH=4 and no reads -> fifo_cnt=4, head = sample 2, STAT read = 8'h03, a second STAT read = 8'h01.
- Push coincident with the popping SS_n rise at fifo_cnt=2 -> fifo_cnt stays 2, overrun stays 0.
- Write 8'h10=8'h5A, then SS_n rise after 4 bits of the next byte -> reg 7'h10 = 8'h5A, reg 7'h11 unchanged (8'h00); a write to 7'h0F leaves WHO_AM_I = 8'h6A.
- Assert rst_n low mid-burst with fifo_cnt=3 -> INT=0, fifo_cnt=0, registers cleared; a new read of 7'h0D returns 8'h00.
